arm_datapath: RTL and testbench
===============================

Name: arm_datapath

Overview:
- 32-bit ARM-style execute datapath for the multi-cycle CPU.
- Contains a 16x32 register file with two write ports, three read ports (A, B, shift amount), and operand registers A, B and S.
- Also contains a barrel shifter, a 3-bit-opcode ALU and an NZCV status register.
- All control comes from the CPU controller; the combinational ALU result is exported for write-back.

Parameters:
- NREGS, 16, number of architectural registers (address width 4).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- w_addr1  in  4  write port 1 address (data = ALU result)
- w_en1  in  1  write port 1 enable
- w_addr2  in  4  write port 2 address (data = shifter output)
- w_en2  in  1  write port 2 enable
- A_addr  in  4  read address for A operand
- B_addr  in  4  read address for B operand
- shift_addr  in  4  read address for register shift amount
- PC  in  32  current program counter
- sel_A_in  in  2  A-register input select
- sel_B_in  in  2  B-register input select
- sel_shift_in  in  1  S-register register-source select
- en_A  in  1  load A register
- en_B  in  1  load B register
- en_S  in  1  load S register
- shift_imme  in  32  immediate shift amount
- sel_shift  in  1  S source: 1 = register, 0 = shift_imme
- shift_op  in  2  shift type
- sel_A  in  1  ALU A operand: 0 = A register, 1 = constant 0
- sel_B  in  1  ALU B operand: 0 = post-shift mux output, 1 = imme_data
- sel_post_shift  in  1  post-shift mux: 0 = shifter output, 1 = unshifted B register
- imme_data  in  32  immediate operand
- ALU_op  in  3  ALU operation
- en_status  in  1  load status register
- datapath_out  out  32  combinational ALU result
- status_out  out  32  {N,Z,C,V,28'b0}

Behaviour:
- Reset (async): all 16 registers, A, B, S and status cleared to 0. datapath_out is therefore 0 + 0 = 0 when ALU_op = ADD.
- Register file:
  - Synchronous writes on clk rising edge.
  - Port 1 writes datapath_out; port 2 writes the shifter output.
  - If both ports write the same address in one cycle, port 1 wins.
  - Reads are combinational with no write bypass: A/B/S loaded on the same edge as a write capture the old value.
- A register, on en_A: sel_A_in 01 = datapath_out, 10 = PC, any other value (including X/unknown) = regfile[A_addr].
- B register, on en_B: same encoding as A, using regfile[B_addr].
- S register, on en_S:
  - sel_shift = 0: S <= shift_imme.
  - sel_shift = 1, sel_shift_in = 1: S <= datapath_out.
  - sel_shift = 1, sel_shift_in otherwise (including X): S <= regfile[shift_addr].
- Shifter input and amount: input = B register; amount = S[7:0].
  - Shift amount is latched in S and does not track later changes of sel_shift or shift_imme.
- shift_op encodings:
  - 00 LSL: amount >= 32 gives 0.
  - 01 LSR: amount >= 32 gives 0.
  - 10 ASR: amount >= 32 gives sign fill.
  - 11 ROR: rotate by amount mod 32.
  - Amount 0 passes B unchanged for every op.
- ALU operations, result = datapath_out:
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND
  - 011 ORR
  - 100 EOR
  - 101 MOV: B
  - 110 MVN: ~B
  - 111 BIC: A & ~B
- Flags:
  - N = result[31]; Z = (result == 0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: computed as A + ~B + 1; C = carry out (1 = no borrow); V = signed overflow.
  - Logical ops: C = 0, V = 0.
- Status register: loads {N,Z,C,V,28'b0} on en_status; otherwise holds.

Optional Feature:
- Macro SHIFTER_CARRY_EN.
- Defined:
  - The shifter produces a carry-out: last bit shifted out, or B[31] for ROR.
  - Logical ops set C from that carry-out; shift amount 0 keeps the old C.
- Undefined: logical ops clear C as above.

Decomposition:
- Package arm_datapath_pkg holds:
  - alu_op_e (8 codes)
  - shift_op_e (LSL/LSR/ASR/ROR)
  - flag bit index constants N=31, Z=30, C=29, V=28
  - sel_*_in source codes
- One sub-module, arm_regfile: 16x32, two write ports, three combinational read ports, async reset.

Test Plan:
- Load registers: for i in 0..15, sel_A=1, sel_B=1, imme_data=i, ALU_op=ADD, w_en1, write ri. Then reads of r1 and r2 via A/B -> 1 and 2.
- Register-amount shift: A=r1, B=r2, sel_shift=1, shift_addr=1, load A/B/S. Then sel_shift=0, shift_imme=0, LSL, ADD -> datapath_out = 5 (S holds 1); en_status -> status_out = 0.
- Immediate subtract: sel_A=1, sel_B=1, imme_data=12, SUB -> 0xFFFFFFF4; status_out = 0x80000000.
- Negate: write -12 to r0, B=r0, S=0, sel_A=1, sel_B=0, SUB -> 12; status = 0 (C=0).
- Post-shift bypass: A=r0(-12), B=r2, S=2, sel_post_shift=1, ADD -> -10. Same cycle w_en2 to r0 -> r0 = 8; read back -> 8.
- Edge cases:
  - ADD 0x7FFFFFFF+1 -> N=1, V=1.
  - ADD 0xFFFFFFFF+1 -> Z=1, C=1.
  - ASR 0x80000000 by 40 -> 0xFFFFFFFF.
  - Async rst mid-sequence clears status and registers.

Source files
------------

// File: rtl/arm_datapath_pkg.sv
// Shared types and constants for the ARM-style execute datapath.
// Latency: n/a (types only). Backpressure: n/a.
// Holds ALU/shift opcode enums, NZCV bit positions and operand-source codes.
package arm_datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101,
        ALU_MVN = 3'b110,
        ALU_BIC = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    localparam int FLAG_N = 31;
    localparam int FLAG_Z = 30;
    localparam int FLAG_C = 29;
    localparam int FLAG_V = 28;

    // Operand register (A/B) load sources; anything else selects the register file.
    localparam logic [1:0] SEL_IN_REG = 2'b00;
    localparam logic [1:0] SEL_IN_ALU = 2'b01;
    localparam logic [1:0] SEL_IN_PC  = 2'b10;

    localparam logic SEL_SHIFT_IN_REG = 1'b0;
    localparam logic SEL_SHIFT_IN_ALU = 1'b1;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic [31:0] pack_status(input flags_t f);
        logic [31:0] s;
        s         = '0;
        s[FLAG_N] = f.n;
        s[FLAG_Z] = f.z;
        s[FLAG_C] = f.c;
        s[FLAG_V] = f.v;
        return s;
    endfunction

endpackage

// File: rtl/arm_regfile.sv
// 16x32 register file: two synchronous write ports (port 1 wins on collision), three comb reads.
// Latency: write visible one cycle after the edge; reads are combinational with no bypass.
// Backpressure: none, writes always accepted.
module arm_regfile
    import arm_datapath_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_w_addr1,
    input  logic          i_w_en1,
    input  logic [DW-1:0] i_w_dat1,
    input  logic [AW-1:0] i_w_addr2,
    input  logic          i_w_en2,
    input  logic [DW-1:0] i_w_dat2,
    input  logic [AW-1:0] i_rd_addr_a,
    input  logic [AW-1:0] i_rd_addr_b,
    input  logic [AW-1:0] i_rd_addr_s,
    output logic [DW-1:0] o_rd_dat_a,
    output logic [DW-1:0] o_rd_dat_b,
    output logic [DW-1:0] o_rd_dat_s
);

    logic [DW-1:0] r_mem [NREGS];

    // Port 2 is applied first so that port 1 overrides it on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_w_en2) begin
                r_mem[i_w_addr2] <= i_w_dat2;
            end
            if (i_w_en1) begin
                r_mem[i_w_addr1] <= i_w_dat1;
            end
        end
    end

    assign o_rd_dat_a = r_mem[i_rd_addr_a];
    assign o_rd_dat_b = r_mem[i_rd_addr_b];
    assign o_rd_dat_s = r_mem[i_rd_addr_s];

endmodule

// File: rtl/arm_datapath.sv
// ARM-style execute datapath: regfile, A/B/S operand regs, barrel shifter, ALU, NZCV status.
// Latency: datapath_out is combinational from A/B/S; status_out registered on en_status.
// Backpressure: none. Optional SHIFTER_CARRY_EN routes the shifter carry into C for logical ops.
module arm_datapath
    import arm_datapath_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    w_addr1,
    input  logic          w_en1,
    input  logic [3:0]    w_addr2,
    input  logic          w_en2,
    input  logic [3:0]    A_addr,
    input  logic [3:0]    B_addr,
    input  logic [3:0]    shift_addr,
    input  logic [DW-1:0] PC,
    input  logic [1:0]    sel_A_in,
    input  logic [1:0]    sel_B_in,
    input  logic          sel_shift_in,
    input  logic          en_A,
    input  logic          en_B,
    input  logic          en_S,
    input  logic [DW-1:0] shift_imme,
    input  logic          sel_shift,
    input  logic [1:0]    shift_op,
    input  logic          sel_A,
    input  logic          sel_B,
    input  logic          sel_post_shift,
    input  logic [DW-1:0] imme_data,
    input  logic [2:0]    ALU_op,
    input  logic          en_status,
    output logic [DW-1:0] datapath_out,
    output logic [31:0]   status_out
);

    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_s;
    logic [31:0]   r_status;

    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;
    logic [DW-1:0] w_rd_s;
    logic [DW-1:0] w_res;
    logic [DW-1:0] w_shift;
    logic          w_sh_c;

    arm_regfile #(
        .NREGS(NREGS),
        .DW   (DW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_w_addr1  (w_addr1),
        .i_w_en1    (w_en1),
        .i_w_dat1   (w_res),
        .i_w_addr2  (w_addr2),
        .i_w_en2    (w_en2),
        .i_w_dat2   (w_shift),
        .i_rd_addr_a(A_addr),
        .i_rd_addr_b(B_addr),
        .i_rd_addr_s(shift_addr),
        .o_rd_dat_a (w_rd_a),
        .o_rd_dat_b (w_rd_b),
        .o_rd_dat_s (w_rd_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_s <= '0;
        end else begin
            if (en_A) begin
                case (sel_A_in)
                    SEL_IN_ALU: r_a <= w_res;
                    SEL_IN_PC:  r_a <= PC;
                    default:    r_a <= w_rd_a;
                endcase
            end
            if (en_B) begin
                case (sel_B_in)
                    SEL_IN_ALU: r_b <= w_res;
                    SEL_IN_PC:  r_b <= PC;
                    default:    r_b <= w_rd_b;
                endcase
            end
            if (en_S) begin
                if (!sel_shift) begin
                    r_s <= shift_imme;
                end else if (sel_shift_in == SEL_SHIFT_IN_ALU) begin
                    r_s <= w_res;
                end else begin
                    r_s <= w_rd_s;
                end
            end
        end
    end

    // Shifts run on a double-width vector so the bit just past the result is the carry-out
    // and amounts of 32..255 saturate naturally.
    logic [7:0]      w_amt;
    logic [2*DW-1:0] w_lsl;
    logic [2*DW-1:0] w_lsr;
    logic [2*DW-1:0] w_asr;
    logic [2*DW-1:0] w_ror;

    assign w_amt = r_s[7:0];
    assign w_lsl = {{DW{1'b0}}, r_b} << w_amt;
    assign w_lsr = {r_b, {DW{1'b0}}} >> w_amt;
    assign w_asr = $signed({r_b, {DW{1'b0}}}) >>> w_amt;
    assign w_ror = {r_b, r_b} >> w_amt[4:0];

    always_comb begin
        w_shift = r_b;
        w_sh_c  = r_status[FLAG_C];
        if (w_amt != 8'd0) begin
            case (shift_op_e'(shift_op))
                SH_LSL: begin
                    w_shift = w_lsl[DW-1:0];
                    w_sh_c  = w_lsl[DW];
                end
                SH_LSR: begin
                    w_shift = w_lsr[2*DW-1:DW];
                    w_sh_c  = w_lsr[DW-1];
                end
                SH_ASR: begin
                    w_shift = w_asr[2*DW-1:DW];
                    w_sh_c  = w_asr[DW-1];
                end
                SH_ROR: begin
                    w_shift = w_ror[DW-1:0];
                    w_sh_c  = r_b[DW-1];
                end
                default: begin
                    w_shift = r_b;
                end
            endcase
        end
    end

    logic [DW-1:0] w_alu_a;
    logic [DW-1:0] w_alu_b;
    logic [DW-1:0] w_post;
    logic [DW:0]   w_sum;
    logic          w_c;
    logic          w_v;
    logic          w_logic_c;
    logic          w_unused;
    flags_t        w_flags;

    assign w_post  = sel_post_shift ? r_b : w_shift;
    assign w_alu_a = sel_A ? '0 : r_a;
    assign w_alu_b = sel_B ? imme_data : w_post;

`ifdef SHIFTER_CARRY_EN
    assign w_logic_c = w_sh_c;
    assign w_unused  = ^{r_s[DW-1:8], w_lsl[2*DW-1:DW+1], w_lsr[DW-2:0],
                         w_asr[DW-2:0], w_ror[2*DW-1:DW]};
`else
    assign w_logic_c = 1'b0;
    assign w_unused  = ^{r_s[DW-1:8], w_lsl[2*DW-1:DW+1], w_lsr[DW-2:0],
                         w_asr[DW-2:0], w_ror[2*DW-1:DW], w_sh_c};
`endif

    // SUB is A + ~B + 1, so C reads as "no borrow".
    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = w_logic_c;
        w_v   = 1'b0;
        case (alu_op_e'(ALU_op))
            ALU_ADD: begin
                w_sum = {1'b0, w_alu_a} + {1'b0, w_alu_b};
                w_res = w_sum[DW-1:0];
                w_c   = w_sum[DW];
                w_v   = (w_alu_a[DW-1] == w_alu_b[DW-1]) && (w_res[DW-1] != w_alu_a[DW-1]);
            end
            ALU_SUB: begin
                w_sum = {1'b0, w_alu_a} + {1'b0, ~w_alu_b} + {{DW{1'b0}}, 1'b1};
                w_res = w_sum[DW-1:0];
                w_c   = w_sum[DW];
                w_v   = (w_alu_a[DW-1] != w_alu_b[DW-1]) && (w_res[DW-1] != w_alu_a[DW-1]);
            end
            ALU_AND: w_res = w_alu_a & w_alu_b;
            ALU_ORR: w_res = w_alu_a | w_alu_b;
            ALU_EOR: w_res = w_alu_a ^ w_alu_b;
            ALU_MOV: w_res = w_alu_b;
            ALU_MVN: w_res = ~w_alu_b;
            ALU_BIC: w_res = w_alu_a & ~w_alu_b;
            default: w_res = '0;
        endcase
    end

    assign w_flags.n = w_res[DW-1];
    assign w_flags.z = (w_res == '0);
    assign w_flags.c = w_c;
    assign w_flags.v = w_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else if (en_status) begin
            r_status <= pack_status(w_flags);
        end
    end

    assign datapath_out = w_res;
    assign status_out   = r_status;

endmodule

// File: tb/tb_arm_datapath.sv
// Directed bench for arm_datapath: table of ALU/shifter vectors plus hand-written sequences
// for regfile writes, operand sourcing, no-bypass reads and asynchronous reset.
module tb_arm_datapath;
    import arm_datapath_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  w_addr1, w_addr2, A_addr, B_addr, shift_addr;
    logic        w_en1, w_en2;
    logic [31:0] PC, shift_imme, imme_data;
    logic [1:0]  sel_A_in, sel_B_in, shift_op;
    logic        sel_shift_in, en_A, en_B, en_S, sel_shift;
    logic        sel_A, sel_B, sel_post_shift, en_status;
    logic [2:0]  ALU_op;
    logic [31:0] datapath_out, status_out;

    int errors;
    int n_checks;

    arm_datapath dut (
        .clk(clk), .rst(rst),
        .w_addr1(w_addr1), .w_en1(w_en1), .w_addr2(w_addr2), .w_en2(w_en2),
        .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr), .PC(PC),
        .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
        .en_A(en_A), .en_B(en_B), .en_S(en_S), .shift_imme(shift_imme),
        .sel_shift(sel_shift), .shift_op(shift_op), .sel_A(sel_A), .sel_B(sel_B),
        .sel_post_shift(sel_post_shift), .imme_data(imme_data), .ALU_op(ALU_op),
        .en_status(en_status), .datapath_out(datapath_out), .status_out(status_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  amt;
        logic [1:0]  sop;
        logic [2:0]  op;
        logic        post;
        logic [31:0] exp_out;
        logic [3:0]  exp_f;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        w_addr1 = 4'd0; w_en1 = 1'b0; w_addr2 = 4'd0; w_en2 = 1'b0;
        A_addr = 4'd0; B_addr = 4'd0; shift_addr = 4'd0; PC = 32'd0;
        sel_A_in = SEL_IN_REG; sel_B_in = SEL_IN_REG; sel_shift_in = 1'b0;
        en_A = 1'b0; en_B = 1'b0; en_S = 1'b0; shift_imme = 32'd0; sel_shift = 1'b0;
        shift_op = SH_LSL; sel_A = 1'b0; sel_B = 1'b0; sel_post_shift = 1'b0;
        imme_data = 32'd0; ALU_op = ALU_ADD; en_status = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives datapath_out to a constant: 0 + imme_data.
    task automatic drive_imm(input logic [31:0] v);
        sel_A = 1'b1; sel_B = 1'b1; imme_data = v; ALU_op = ALU_ADD;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        idle(); drive_imm(v.a); sel_A_in = SEL_IN_ALU; en_A = 1'b1;
        shift_imme = {24'd0, v.amt}; en_S = 1'b1;
        step();
        idle(); drive_imm(v.b); sel_B_in = SEL_IN_ALU; en_B = 1'b1;
        step();
        idle(); sel_post_shift = v.post; shift_op = v.sop; ALU_op = v.op; en_status = 1'b1;
        #1;
        check($sformatf("vec%0d out", idx), datapath_out, v.exp_out);
        step();
        check($sformatf("vec%0d status", idx), status_out, {v.exp_f, 28'd0});
    endtask

    initial begin
        errors = 0;
        n_checks = 0;
        //            a             b             amt    sop     op       post  exp_out       NZCV
        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 8'd0,  SH_LSL, ALU_ADD, 1'b0, 32'h80000000, 4'b1001};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 8'd0,  SH_LSL, ALU_ADD, 1'b0, 32'h00000000, 4'b0110};
        vecs[2]  = '{32'h00000000, 32'h80000000, 8'd40, SH_ASR, ALU_MOV, 1'b0, 32'hFFFFFFFF, 4'b1000};
        vecs[3]  = '{32'h00000005, 32'h00000003, 8'd0,  SH_LSL, ALU_SUB, 1'b0, 32'h00000002, 4'b0010};
        vecs[4]  = '{32'h00000003, 32'h00000005, 8'd0,  SH_LSL, ALU_SUB, 1'b0, 32'hFFFFFFFE, 4'b1000};
        vecs[5]  = '{32'h80000000, 32'h00000001, 8'd0,  SH_LSL, ALU_SUB, 1'b0, 32'h7FFFFFFF, 4'b0011};
        vecs[6]  = '{32'h00000000, 32'h00000001, 8'd4,  SH_LSL, ALU_MOV, 1'b0, 32'h00000010, 4'b0000};
        vecs[7]  = '{32'h00000000, 32'h80000000, 8'd31, SH_LSR, ALU_MOV, 1'b0, 32'h00000001, 4'b0000};
        vecs[8]  = '{32'h00000000, 32'hFFFFFFFF, 8'd32, SH_LSL, ALU_MOV, 1'b0, 32'h00000000, 4'b0100};
        vecs[9]  = '{32'h00000000, 32'hFFFFFFFF, 8'd32, SH_LSR, ALU_MOV, 1'b0, 32'h00000000, 4'b0100};
        vecs[10] = '{32'h00000000, 32'h12345678, 8'd8,  SH_ROR, ALU_MOV, 1'b0, 32'h78123456, 4'b0000};
        vecs[11] = '{32'h00000000, 32'h000000F1, 8'd36, SH_ROR, ALU_MOV, 1'b0, 32'h1000000F, 4'b0000};
        vecs[12] = '{32'h00000000, 32'h80000000, 8'd4,  SH_ASR, ALU_MOV, 1'b0, 32'hF8000000, 4'b1000};
        vecs[13] = '{32'hFF00FF00, 32'h0FF00FF0, 8'd0,  SH_LSL, ALU_AND, 1'b0, 32'h0F000F00, 4'b0000};
        vecs[14] = '{32'hF0000000, 32'h0000000F, 8'd0,  SH_LSL, ALU_ORR, 1'b0, 32'hF000000F, 4'b1000};
        vecs[15] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 8'd0,  SH_LSL, ALU_EOR, 1'b0, 32'h00000000, 4'b0100};
        vecs[16] = '{32'h00000000, 32'h00000000, 8'd0,  SH_LSL, ALU_MVN, 1'b0, 32'hFFFFFFFF, 4'b1000};
        vecs[17] = '{32'hFFFFFFFF, 32'h0000FFFF, 8'd0,  SH_LSL, ALU_BIC, 1'b0, 32'hFFFF0000, 4'b1000};
        vecs[18] = '{32'h00000000, 32'h40000000, 8'd40, SH_ASR, ALU_MOV, 1'b0, 32'h00000000, 4'b0100};
        vecs[19] = '{32'h00000000, 32'h80000001, 8'd0,  SH_ROR, ALU_MOV, 1'b0, 32'h80000001, 4'b1000};
        vecs[20] = '{32'h00000001, 32'h00000003, 8'd4,  SH_LSL, ALU_ADD, 1'b1, 32'h00000004, 4'b0000};

        idle();
        rst = 1'b1;
        #12;
        check("reset out", datapath_out, 32'd0);
        check("reset status", status_out, 32'd0);
        rst = 1'b0;
        step();

        // Fill r0..r15 with their index through write port 1.
        for (int i = 0; i < 16; i++) begin
            idle(); drive_imm(i); w_en1 = 1'b1; w_addr1 = 4'(i);
            step();
        end
        idle(); A_addr = 4'd1; B_addr = 4'd2; en_A = 1'b1; en_B = 1'b1;
        step();
        idle(); sel_B = 1'b1; #1;
        check("read r1 via A", datapath_out, 32'd1);
        idle(); sel_A = 1'b1; sel_post_shift = 1'b1; #1;
        check("read r2 via B", datapath_out, 32'd2);

        // Register-sourced shift amount, latched in S.
        idle(); A_addr = 4'd1; B_addr = 4'd2; shift_addr = 4'd1; sel_shift = 1'b1;
        en_A = 1'b1; en_B = 1'b1; en_S = 1'b1;
        step();
        idle(); en_status = 1'b1; #1;
        check("reg shift add", datapath_out, 32'd5);
        step();
        check("reg shift status", status_out, 32'd0);

        // PC into A, ALU result into B and S.
        idle(); PC = 32'h1000; sel_A_in = SEL_IN_PC; en_A = 1'b1; drive_imm(32'd3);
        sel_B_in = SEL_IN_ALU; en_B = 1'b1; sel_shift = 1'b1; sel_shift_in = 1'b1; en_S = 1'b1;
        step();
        idle(); #1;
        check("pc plus shifted alu", datapath_out, 32'h1018);

        // Immediate subtract, result also written to r0.
        idle(); sel_A = 1'b1; sel_B = 1'b1; imme_data = 32'd12; ALU_op = ALU_SUB;
        en_status = 1'b1; w_en1 = 1'b1; w_addr1 = 4'd0; #1;
        check("imm sub", datapath_out, 32'hFFFFFFF4);
        step();
        check("imm sub status", status_out, 32'h80000000);

        // Negate r0.
        idle(); B_addr = 4'd0; en_B = 1'b1; en_S = 1'b1;
        step();
        idle(); sel_A = 1'b1; ALU_op = ALU_SUB; en_status = 1'b1; #1;
        check("negate", datapath_out, 32'd12);
        step();
        check("negate status", status_out, 32'd0);

        // Post-shift bypass with a concurrent shifter write-back to r0.
        idle(); A_addr = 4'd0; B_addr = 4'd2; en_A = 1'b1; en_B = 1'b1;
        shift_imme = 32'd2; en_S = 1'b1;
        step();
        idle(); sel_post_shift = 1'b1; w_en2 = 1'b1; w_addr2 = 4'd0; #1;
        check("post shift bypass", datapath_out, 32'hFFFFFFF6);
        step();
        idle(); A_addr = 4'd0; en_A = 1'b1;
        step();
        idle(); sel_B = 1'b1; #1;
        check("port2 writeback r0", datapath_out, 32'd8);

        // Both write ports on r5: port 1 must win over shifter output 8.
        idle(); drive_imm(32'h55); w_en1 = 1'b1; w_addr1 = 4'd5; w_en2 = 1'b1; w_addr2 = 4'd5;
        step();
        idle(); A_addr = 4'd5; en_A = 1'b1;
        step();
        idle(); sel_B = 1'b1; #1;
        check("port1 wins", datapath_out, 32'h55);

        // A loaded on the same edge as a write to its source sees the old value.
        idle(); A_addr = 4'd6; en_A = 1'b1; drive_imm(32'h99); w_en1 = 1'b1; w_addr1 = 4'd6;
        step();
        idle(); sel_B = 1'b1; #1;
        check("no bypass old", datapath_out, 32'd6);
        idle(); A_addr = 4'd6; en_A = 1'b1;
        step();
        idle(); sel_B = 1'b1; #1;
        check("no bypass new", datapath_out, 32'h99);

        // Asynchronous reset in the middle of a cycle.
        idle(); sel_A = 1'b1; sel_B = 1'b1; imme_data = 32'd12; ALU_op = ALU_SUB; en_status = 1'b1;
        step();
        check("pre-reset status", status_out, 32'h80000000);
        idle(); sel_B = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async rst status", status_out, 32'd0);
        check("async rst A", datapath_out, 32'd0);
        #1;
        rst = 1'b0;
        step();
        idle(); A_addr = 4'd1; en_A = 1'b1;
        step();
        idle(); sel_B = 1'b1; #1;
        check("async rst r1", datapath_out, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(vecs[i], i);
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
